// File: rtl/sg_pkg.sv
// Shared constants and FSM encoding for the segmenter read/write paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sg_pkg;

  localparam int sg_data_width     = 64;
  localparam int sg_address_width  = 12;
  localparam int sg_len_width      = 6;
  localparam int sg_des_width      = 4;
  localparam int sg_priority_width = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } sg_state_e;

endpackage

// File: rtl/datard_fifo.sv
// Synchronous FIFO buffering SRAM read data ahead of the egress port.
// Latency: a pushed word is visible on head_data the cycle after the push.
// Backpressure: push ignored when full (unless popping), pop ignored when empty.
// Ports: clk/rst, push + push_data, pop, head_data (current head), full, empty, count (entries held).
module datard_fifo #(
  parameter int width = 64,
  parameter int depth = 4,
  localparam int ptr_w = $clog2(depth),
  localparam int cnt_w = ptr_w + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [cnt_w-1:0] count
);

  logic [width-1:0] mem_q [depth];
  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == cnt_w'(depth));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ptr_w'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_w'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + cnt_w'(1);
      2'b01:   count_d = count_q - cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared so the head reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/datard.sv
// Packet read engine: turns a descriptor into per-word SRAM reads and streams the words out with eop.
// Latency: grant at cycle N -> word on data_out at N+2 when the buffer was empty; 1 word/cycle sustained.
// Backpressure: ready_in low holds the head; reads are only requested while buffer credit remains.
// Ports: start/address_in/length_in/priority_in/des_port_in descriptor; request/rd_priority/address_read/
//  grant/data_read arbiter side; data_out/valid_out/eop/des_port/ready_in egress side; busy status.
module datard
  import sg_pkg::*;
#(
  parameter int fifo_depth = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [sg_address_width-1:0]  address_in,
  input  logic [sg_len_width-1:0]      length_in,
  input  logic [sg_priority_width-1:0] priority_in,
  input  logic [sg_des_width-1:0]      des_port_in,
  output logic                         busy,
  output logic                         request,
  output logic [sg_priority_width-1:0] rd_priority,
  output logic [sg_address_width-1:0]  address_read,
  input  logic                         grant,
  input  logic [sg_data_width-1:0]     data_read,
  output logic [sg_data_width-1:0]     data_out,
  output logic                         valid_out,
  output logic                         eop,
  output logic [sg_des_width-1:0]      des_port,
  input  logic                         ready_in
);

  localparam int cnt_w = $clog2(fifo_depth) + 1;
  localparam logic [cnt_w:0] depth_c = (cnt_w + 1)'(fifo_depth);

  sg_state_e                    state_q, state_d;
  logic [sg_address_width-1:0]  addr_q, addr_d;
  logic [sg_len_width-1:0]      len_q, len_d;
  logic [sg_priority_width-1:0] prio_q, prio_d;
  logic [sg_des_width-1:0]      port_q, port_d;
  logic [sg_len_width-1:0]      issued_q, issued_d;
  logic [sg_len_width-1:0]      delivered_q, delivered_d;
  logic                         inflight_q, inflight_d;

  logic                         fifo_full;
  logic                         fifo_empty;
  logic [cnt_w-1:0]             fifo_count;
  logic                         fifo_pop;
  logic [cnt_w:0]               occupancy;
  logic                         credit_ok;

  datard_fifo #(
    .width (sg_data_width),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (data_read),
    .pop       (fifo_pop),
    .head_data (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign valid_out    = !fifo_empty;
  assign fifo_pop     = valid_out && ready_in;
  assign eop          = valid_out && (delivered_q == len_q - sg_len_width'(1));
  assign busy         = (state_q != IDLE);
  assign rd_priority  = prio_q;
  assign address_read = addr_q;
  assign des_port     = port_q;

  // The read in flight already owns a buffer slot, so it counts against the credit.
  assign occupancy = {1'b0, fifo_count} + {{cnt_w{1'b0}}, inflight_q};
  assign credit_ok = !fifo_full && (occupancy < depth_c);

  assign inflight_d = request && grant;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    prio_d      = prio_q;
    port_d      = port_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    request     = 1'b0;

    if (fifo_pop) delivered_d = delivered_q + sg_len_width'(1);

    case (state_q)
      IDLE: begin
        if (start && (length_in != '0)) begin
          addr_d      = address_in;
          len_d       = length_in;
          prio_d      = priority_in;
          port_d      = des_port_in;
          issued_d    = '0;
          delivered_d = '0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        request = (issued_q != len_q) && credit_ok;
        if (request && grant) begin
          addr_d   = addr_q + sg_address_width'(1);
          issued_d = issued_q + sg_len_width'(1);
        end
        if (issued_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave as the last word is popped so busy drops right after it goes out.
        if (delivered_d == len_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      prio_q      <= '0;
      port_q      <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      prio_q      <= prio_d;
      port_q      <= port_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      inflight_q  <= inflight_d;
    end
  end

endmodule

// File: tb/tb_datard.sv
// Bench for datard: SRAM + arbiter + egress model, expected beats derived from the descriptor.
// Latency: n/a.
// Backpressure: grant and ready_in are throttled randomly or held off by directed stalls.
module tb_datard;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] address_in;
  logic [5:0]  length_in;
  logic [2:0]  priority_in;
  logic [3:0]  des_port_in;
  logic        busy;
  logic        request;
  logic [2:0]  rd_priority;
  logic [11:0] address_read;
  logic        grant;
  logic [63:0] data_read;
  logic [63:0] data_out;
  logic        valid_out;
  logic        eop;
  logic [3:0]  des_port;
  logic        ready_in;

  datard dut (
    .clk(clk), .rst(rst), .start(start), .address_in(address_in), .length_in(length_in),
    .priority_in(priority_in), .des_port_in(des_port_in), .busy(busy), .request(request),
    .rd_priority(rd_priority), .address_read(address_read), .grant(grant), .data_read(data_read),
    .data_out(data_out), .valid_out(valid_out), .eop(eop), .des_port(des_port), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dat;
    logic        eop;
  } beat_t;

  logic [63:0] sram [4096];
  beat_t       exp_q[$];
  logic [11:0] exp_addr;
  logic [2:0]  exp_prio;
  logic [3:0]  exp_port;
  int          exp_len;
  bit          model_busy;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int grant_pct = 100, ready_pct = 100;
  int grant_hold = 0, ready_hold = 0;
  int pkt_granted, pkt_popped;
  int first_gnt_cyc, last_gnt_cyc, first_beat_cyc, last_beat_cyc;

  logic        req_prev, gnt_prev, vld_prev, rdy_prev, eop_prev, busy_low_chk;
  logic [11:0] addr_prev;
  logic [2:0]  prio_prev;
  logic [63:0] dout_prev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic reset_checks();
    check("rst_busy", busy, 0);
    check("rst_request", request, 0);
    check("rst_valid", valid_out, 0);
    check("rst_eop", eop, 0);
    check("rst_prio", rd_priority, 0);
    check("rst_addr", address_read, 0);
    check("rst_port", des_port, 0);
    check("rst_data", data_out, 0);
  endtask

  // Descriptor is accepted only when the model says the engine is idle and length is non-zero.
  task automatic send(input logic [11:0] a, input logic [5:0] l, input logic [2:0] p, input logic [3:0] d);
    bit    accept;
    beat_t b;
    accept = !model_busy && (l != 0);
    start = 1'b1; address_in = a; length_in = l; priority_in = p; des_port_in = d;
    if (accept) begin
      for (int i = 0; i < int'(l); i++) begin
        b.dat = sram[a + 12'(i)];
        b.eop = (i == int'(l) - 1);
        exp_q.push_back(b);
      end
      exp_addr = a; exp_prio = p; exp_port = d; exp_len = int'(l);
      pkt_granted = 0; pkt_popped = 0;
      first_gnt_cyc = -1; first_beat_cyc = -1;
      model_busy = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    address_in = 12'($urandom); length_in = 6'($urandom);
    priority_in = 3'($urandom); des_port_in = 4'($urandom);
    if (accept) check("busy_rise", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((model_busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("timeout_idle", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // which: 0 = valid_out, 1 = request, 2 = two beats delivered
  task automatic wait_for(input int which);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 500) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = valid_out;
        1:       hit = request;
        default: hit = (pkt_popped >= 2);
      endcase
    end
    if (!hit) check("timeout_wait", which, 99);
  endtask

  // Arbiter, SRAM and egress model; everything is decided and sampled on the falling edge.
  initial begin
    req_prev = 0; gnt_prev = 0; vld_prev = 0; rdy_prev = 0; eop_prev = 0; busy_low_chk = 0;
    addr_prev = '0; prio_prev = '0; dout_prev = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        grant = 0; ready_in = 0;
        req_prev = 0; gnt_prev = 0; vld_prev = 0; busy_low_chk = 0;
      end else begin
        data_read = gnt_prev ? sram[addr_prev] : {$urandom, $urandom};
        if (busy_low_chk) begin
          check("busy_fall", busy, 0);
          busy_low_chk = 0;
        end
        if (req_prev && !gnt_prev) begin
          check("req_hold", request, 1);
          check("addr_hold", address_read, addr_prev);
          check("prio_hold", rd_priority, prio_prev);
        end
        if (vld_prev && !rdy_prev) begin
          check("vld_hold", valid_out, 1);
          check("dat_hold", data_out, dout_prev);
          check("eop_hold", eop, eop_prev);
        end
        if (grant_hold > 0) begin grant = 0; grant_hold--; end
        else grant = (int'($urandom_range(99)) < grant_pct);
        if (ready_hold > 0) begin ready_in = 0; ready_hold--; end
        else ready_in = (int'($urandom_range(99)) < ready_pct);

        if (request && grant) begin
          check("rd_addr", address_read, exp_addr);
          check("rd_prio", rd_priority, exp_prio);
          exp_addr = exp_addr + 12'd1;
          pkt_granted++;
          check("overissue", pkt_granted <= exp_len, 1);
          check("credit", (pkt_granted - pkt_popped) <= 4, 1);
          if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
          last_gnt_cyc = cyc;
        end
        if (valid_out && ready_in) begin
          if (exp_q.size() == 0) check("extra_beat", 1, 0);
          else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat_data", data_out, e.dat);
            check("beat_eop", eop, e.eop);
            check("beat_port", des_port, exp_port);
            pkt_popped++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            if (e.eop) begin model_busy = 0; busy_low_chk = 1; end
          end
        end
        req_prev = request; gnt_prev = request && grant;
        addr_prev = address_read; prio_prev = rd_priority;
        vld_prev = valid_out; rdy_prev = ready_in; dout_prev = data_out; eop_prev = eop;
      end
    end
  end

  initial begin
    rst = 1; start = 0; address_in = 0; length_in = 0; priority_in = 0; des_port_in = 0;
    grant = 0; data_read = 0; ready_in = 0; model_busy = 0; exp_len = 0;
    exp_addr = 0; exp_prio = 0; exp_port = 0;
    pkt_granted = 0; pkt_popped = 0;
    first_gnt_cyc = -1; last_gnt_cyc = 0; first_beat_cyc = -1; last_beat_cyc = 0;
    for (int i = 0; i < 4096; i++) sram[i] = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 0;
    @(negedge clk);

    // Full rate, fixed latency.
    send(12'h100, 6'd5, 3'd6, 4'd9);
    check("t1_port", des_port, 9);
    wait_idle();
    check("t1_latency", first_beat_cyc - first_gnt_cyc, 2);
    check("t1_grant_run", last_gnt_cyc - first_gnt_cyc, 4);
    check("t1_beat_run", last_beat_cyc - first_beat_cyc, 4);

    // Egress stall after first beat.
    send(12'h100, 6'd5, 3'd6, 4'd9);
    wait_for(0);
    ready_hold = 6;
    wait_idle();
    send(12'h200, 6'd12, 3'd2, 4'd3);
    wait_for(0);
    ready_hold = 6;
    repeat (5) @(negedge clk);
    check("req_stall", request, 0);
    wait_idle();

    // Address wrap.
    send(12'hFFE, 6'd4, 3'd1, 4'd7);
    wait_idle();

    // Zero length, and a start while busy.
    send(12'h300, 6'd0, 3'd5, 4'd2);
    for (int i = 0; i < 4; i++) begin
      check("len0_req", request, 0);
      check("len0_busy", busy, 0);
      @(negedge clk);
    end
    grant_pct = 40;
    send(12'h400, 6'd6, 3'd3, 4'hA);
    send(12'h500, 6'd7, 3'd1, 4'h5);
    check("busy_start_port", des_port, 4'hA);
    wait_idle();

    // Grant withheld.
    grant_pct = 100;
    send(12'h600, 6'd5, 3'd4, 4'd1);
    wait_for(1);
    grant_hold = 3;
    @(negedge clk);
    check("gnt_wait_req", request, 1);
    wait_idle();

    // Reset mid-packet, then a single-word packet.
    send(12'h100, 6'd5, 3'd6, 4'd9);
    wait_for(2);
    #2 rst = 1;
    #1 reset_checks();
    exp_q.delete();
    model_busy = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    send(12'h020, 6'd1, 3'd2, 4'd6);
    wait_idle();
    check("single_beats", pkt_popped, 1);

    // Random descriptors and flow control.
    for (int k = 0; k < 25; k++) begin
      grant_pct = int'($urandom_range(30, 100));
      ready_pct = int'($urandom_range(30, 100));
      send(12'($urandom), 6'($urandom_range(1, 63)), 3'($urandom), 4'($urandom));
      wait_idle();
    end
    check("leftover_beats", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
